// File: rtl/matmul_sequencer_pkg.sv
// Shared types and helpers for the matrix-multiply sequencer.
package matmul_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int unsigned ACC_W = 16;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 16'sd127;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -16'sd128;

  function automatic logic sat8_clamps(input logic signed [ACC_W-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] r;
    r = v;
    if (v > SAT_MAX) r = SAT_MAX;
    else if (v < SAT_MIN) r = SAT_MIN;
    return r[7:0];
  endfunction

endpackage

// File: rtl/matmul_sequencer_index_ctr.sv
// Nested i/j/k loop counters (k innermost) with last-k and last-element flags.
module matmul_index_ctr #(
  parameter int unsigned N = 3,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j,
  output logic [IW-1:0] k,
  output logic          last_k,
  output logic          last_elem
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clr) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else if (adv) begin
      if (k_q == LAST) begin
        k_d = '0;
        if (j_q == LAST) begin
          j_d = '0;
          i_d = (i_q == LAST) ? '0 : i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  assign i         = i_q;
  assign j         = j_q;
  assign k         = k_q;
  assign last_k    = (k_q == LAST);
  assign last_elem = last_k && (i_q == LAST) && (j_q == LAST);

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences one shared 8x8 multiplier through C = A x B, one MAC per cycle,
// saturating each element to 8 bits and flagging any overflow.
module matmul_sequencer
  import matmul_sequencer_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N*N*8-1:0]        a_flat,
  input  logic [N*N*8-1:0]        b_flat,
  output logic signed [7:0]       mul_a,
  output logic signed [7:0]       mul_b,
  input  logic signed [7:0]       mul_prod,
  input  logic                    mul_ovf,
  output logic [N*N*8-1:0]        c_flat,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf
);

  localparam int unsigned IW = $clog2(N);

  state_e                  state_q, state_d;
  logic [N*N*8-1:0]        a_q, a_d, b_q, b_d, c_q, c_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, sum;
  logic                    ovf_q, ovf_d;
  logic                    ctr_clr, ctr_adv, last_k, last_elem;
  logic [IW-1:0]           i, j, k;
  int unsigned             a_idx, b_idx, c_idx;

  matmul_index_ctr #(.N(N)) u_idx (
    .clk       (clk),
    .rst       (rst),
    .clr       (ctr_clr),
    .adv       (ctr_adv),
    .i         (i),
    .j         (j),
    .k         (k),
    .last_k    (last_k),
    .last_elem (last_elem)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    ctr_clr = 1'b0;
    ctr_adv = 1'b0;
    mul_a   = '0;
    mul_b   = '0;
    a_idx   = N * 32'(i) + 32'(k);
    b_idx   = N * 32'(k) + 32'(j);
    c_idx   = N * 32'(i) + 32'(j);
    sum     = acc_q + ACC_W'(mul_prod);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = a_flat;
          b_d     = b_flat;
          acc_d   = '0;
          ovf_d   = 1'b0;
          ctr_clr = 1'b1;
        end
      end
      ST_RUN: begin
        ctr_adv = 1'b1;
        // Element selects unrolled as compare-and-pick muxes over the flat vectors.
        for (int unsigned e = 0; e < N * N; e++) begin
          if (e == a_idx) mul_a = a_q[e*8 +: 8];
          if (e == b_idx) mul_b = b_q[e*8 +: 8];
        end
        if (mul_ovf) ovf_d = 1'b1;
        if (last_k) begin
          acc_d = '0;
          if (sat8_clamps(sum)) ovf_d = 1'b1;
          for (int unsigned e = 0; e < N * N; e++) begin
            if (e == c_idx) c_d[e*8 +: 8] = sat8(sum);
          end
        end else begin
          acc_d = sum;
        end
        if (last_elem) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign c_flat = c_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer (N=3) with a wrapping 8-bit multiplier model.
module tb_matmul_sequencer;

  localparam int unsigned N = 3;
  localparam int unsigned W = N * N * 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [W-1:0]       a_flat = '0;
  logic [W-1:0]       b_flat = '0;
  logic signed [7:0]  mul_a, mul_b, mul_prod;
  logic               mul_ovf;
  logic [W-1:0]       c_flat;
  logic               busy, done, ovf;
  logic signed [15:0] full_prod;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int cyc;

  always #5 clk = ~clk;

  assign full_prod = mul_a * mul_b;
  assign mul_prod  = full_prod[7:0];
  assign mul_ovf   = (full_prod > 16'sd127) || (full_prod < -16'sd128);

  matmul_sequencer #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_flat   (a_flat),
    .b_flat   (b_flat),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_prod (mul_prod),
    .mul_ovf  (mul_ovf),
    .c_flat   (c_flat),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] fill(input logic [7:0] v);
    return {(N*N){v}};
  endfunction

  function automatic logic [W-1:0] diag(input logic [7:0] v);
    logic [W-1:0] m = '0;
    for (int r = 0; r < N; r++) m[(r*N+r)*8 +: 8] = v;
    return m;
  endfunction

  function automatic logic [W-1:0] seq(input int scale);
    logic [W-1:0] m = '0;
    for (int e = 0; e < N * N; e++) m[e*8 +: 8] = 8'((e + 1) * scale);
    return m;
  endfunction

  // Presents start for one cycle (edge t); returns in cycle t+1.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    a_flat = a;
    b_flat = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Counts cycles from the current one (numbered n0) to the done cycle, bounded.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    chk("reset_ovf", 128'(ovf), 128'(0));
    chk("reset_c", 128'(c_flat), 128'(0));
    chk("reset_mul", 128'({mul_a, mul_b}), 128'(0));

    // Identity; A changes right after start and must not matter.
    start_op(diag(8'd1), seq(1));
    a_flat = fill(8'd9);
    chk("run_busy", 128'(busy), 128'(1));
    wait_done(1, cyc);
    chk("id_latency", 128'(cyc), 128'(28));
    chk("id_busy_at_done", 128'(busy), 128'(1));
    chk("id_c", 128'(c_flat), 128'(seq(1)));
    chk("id_ovf", 128'(ovf), 128'(0));
    @(negedge clk);
    chk("id_idle_busy", 128'(busy), 128'(0));
    chk("id_idle_mul", 128'({mul_a, mul_b}), 128'(0));

    // Negatives; extra start in RUN and in DONE must be ignored.
    start_op(fill(8'hFF), fill(8'd5));
    repeat (4) @(negedge clk);
    start  = 1'b1;
    a_flat = fill(8'd7);
    @(negedge clk);
    start  = 1'b0;
    wait_done(6, cyc);
    chk("neg_latency", 128'(cyc), 128'(28));
    chk("neg_c", 128'(c_flat), 128'(fill(8'hF1)));
    chk("neg_ovf", 128'(ovf), 128'(0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_ignored", 128'(busy), 128'(0));
    repeat (3) @(negedge clk);
    chk("done_count_2", 128'(done_cnt), 128'(2));

    // Accumulator saturation: 3 x 50 = 150 -> 127.
    start_op(fill(8'd10), fill(8'd5));
    wait_done(1, cyc);
    chk("sat_c", 128'(c_flat), 128'(fill(8'h7F)));
    chk("sat_ovf", 128'(ovf), 128'(1));
    @(negedge clk);
    chk("sat_ovf_hold", 128'(ovf), 128'(1));

    // Multiplier overflow: 200 wraps to -56, 3 x -56 = -168 -> -128.
    start_op(fill(8'd100), fill(8'd2));
    wait_done(1, cyc);
    chk("movf_c", 128'(c_flat), 128'(fill(8'h80)));
    chk("movf_ovf", 128'(ovf), 128'(1));

    // Abort with reset at t+10.
    start_op(fill(8'd1), fill(8'd1));
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_c", 128'(c_flat), 128'(0));
    chk("abort_ovf", 128'(ovf), 128'(0));
    repeat (40) @(negedge clk);
    chk("abort_no_done", 128'(done_cnt), 128'(4));

    // Back-to-back: saturating op, then new A accepted in first IDLE cycle.
    start_op(fill(8'd10), fill(8'd5));
    wait_done(1, cyc);
    chk("b2b_first_ovf", 128'(ovf), 128'(1));
    @(negedge clk);
    a_flat = diag(8'd2);
    b_flat = seq(1);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    chk("b2b_ovf_cleared", 128'(ovf), 128'(0));
    wait_done(2, cyc);
    chk("b2b_gap", 128'(cyc), 128'(29));
    chk("b2b_c", 128'(c_flat), 128'(seq(2)));
    chk("b2b_ovf", 128'(ovf), 128'(0));
    @(negedge clk);
    chk("done_count_total", 128'(done_cnt), 128'(6));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
